vliw_hazard_fwd_unit: RTL
=========================

# vliw_hazard_fwd_unit

Parametrised hazard-detection and forwarding controller for the multi-slot VLIW pipeline. It tracks in-flight register writes from every issue lane across the post-decode stages. It produces per-operand forwarding selects and a load-use stall (PC/IF-ID write inhibit), and keeps a saturating stall counter. It sits beside the decode/EX boundary and replaces the fixed two-lane forwarding unit and hazard detector with one block of configurable lane count, register count and depth.

## Interface
Parameters:
- `LANES`, 2: issue slots per bundle.
- `SRCS`, 2: source operands per lane.
- `NREGS`, 8: architectural registers per file; `REG_AW = $clog2(NREGS)`.
- `STAGES`, 3: tracked stages after decode (0=EX, 1=MEM, 2=WB).
- `CNT_W`, 16: stall counter width.

Ports:
- `clk` in 1: clock, rising edge.
- `reset` in 1: asynchronous, active-high; clears all state.
- `issue_valid` in LANES: lane holds a real instruction in decode.
- `dst_we` in LANES: lane writes a register.
- `dst_is_load` in LANES: lane's write comes from data memory.
- `dst_reg` in LANES*REG_AW: destination per lane.
- `src_valid` in LANES*SRCS: operand is read.
- `src_reg` in LANES*SRCS*REG_AW: operand register; index = lane*SRCS+src.
- `flush` in 1: squash the decode bundle (taken branch/jump/exception).
- `fwd_hit` out LANES*SRCS: operand must take a forwarded value.
- `fwd_stage` out LANES*SRCS*$clog2(STAGES): stage supplying it.
- `fwd_lane` out LANES*SRCS*$clog2(LANES): lane supplying it.
- `stall` out 1: load-use hazard; decode bundle held.
- `pc_write` out 1: `~stall`.
- `ifid_write` out 1: `~stall`.
- `stall_count` out CNT_W: stall cycles since reset, saturating.

## Operation
- Tracker: per stage s, per lane l, a registered entry {valid, reg, is_load}.
- Each clock: entries shift s→s+1; the entry at STAGES-1 retires.
- Stage 0 loads the decode bundle: valid = issue_valid & dst_we & ~stall & ~flush. Otherwise it loads a bubble.
- Match: operand (l,k) matches entry (s,m) when src_valid, entry valid and reg equal.
- Priority: lowest s wins (youngest); within a stage, highest m wins (later slot in program order).
- Intra-bundle dependences are not detected; the compiler guarantees none exist.
- Forward: fwd_hit=1 with stage/lane of the winning match, except when the winner is a load at s=0. Then fwd_hit=0 and the hazard is raised.
- stall = OR over operands of (winning match is s=0 load) & ~flush. A flush overrides a stall.
- With stall asserted, the bubble enters stage 0 and the load moves to stage 1. Next cycle the same operand forwards from s=1 and stall drops. A load-use hazard therefore costs exactly one stall cycle.
- stall_count increments on each cycle with stall=1. It holds at 2^CNT_W-1.

## Timing
- fwd_*, stall, pc_write and ifid_write are combinational from registered tracker state and the current decode inputs. There is no internal latency.
- The tracker and stall_count update on the rising clk.
- Reset (any time, including mid-stall): all entries invalid, stall_count=0. Hence stall=0, pc_write=1, ifid_write=1, fwd_hit=0, fwd_stage=0, fwd_lane=0.
- Outputs remain valid combinationally during reset.
- When flush and stall coincide: stall=0, a bubble is inserted, and the counter does not increment.
- Any operand has no match → fwd_hit=0 and stage/lane=0.

## Configuration
- `VLIW_HDU_ZERO_REG_EN` defined: register 0 is hard-wired zero.
  - Operands and destinations with reg==0 never match, never forward and never stall.
  - Stage-0 entries with dst_reg==0 are written invalid.
- Undefined: register 0 is an ordinary register.

## Structure
- Shared package `vliw_pkg`: tracker entry struct {valid, reg, is_load}, forward-select struct {hit, stage, lane}, and stage index constants (STG_EX=0, STG_MEM=1, STG_WB=2).
- One sub-module `vliw_fwd_select`: one operand's priority match over all STAGES*LANES entries. It returns the select plus a load-hazard flag and is instantiated LANES*SRCS times.
- The top level holds the tracker, stall logic and counter.

## Test plan
- Lane0 writes r3 (non-load); next bundle lane1 reads r3 → fwd_hit=1, stage=0, lane=0, stall=0.
- Lane0 load to r5; next bundle reads r5 → stall=1 and pc_write=0 for one cycle. The following cycle gives fwd_hit=1, stage=1, stall=0, and stall_count goes 0→1.
- Lane0 and lane1 both write r2 in one bundle; next bundle reads r2 → fwd_lane=1. If r2 is instead written again in the next bundle, a third bundle's read gives stage=0 from the newer one.
- Load-use hazard with flush=1 in the same cycle → stall=0, counter unchanged, stage 0 bubble, no later forward from the squashed bundle.
- With `VLIW_HDU_ZERO_REG_EN`: load to r0 then read r0 → fwd_hit=0, stall=0. Without the macro → stall=1.
- Assert reset mid-stall → stall=0, stall_count=0 immediately. Force stall_count to 0xFFFF, then repeat stalls → stays 0xFFFF.

Source files
------------

// File: rtl/vliw_pkg.sv
// Shared types for the VLIW hazard/forwarding unit: tracker entries, forward selects, stage indices.
// Optional feature macro: VLIW_HDU_ZERO_REG_EN (register 0 hard-wired to zero).
package vliw_pkg;

    // Widest register index and select fields carried in the shared structs.
    localparam int REG_AW_MAX = 8;
    localparam int SEL_W_MAX  = 4;

    localparam logic [1:0] STG_EX  = 2'd0;
    localparam logic [1:0] STG_MEM = 2'd1;
    localparam logic [1:0] STG_WB  = 2'd2;

    typedef struct packed {
        logic                  valid;
        logic [REG_AW_MAX-1:0] dreg;
        logic                  is_load;
    } trk_entry_t;

    typedef struct packed {
        logic                 hit;
        logic [SEL_W_MAX-1:0] stage;
        logic [SEL_W_MAX-1:0] lane;
    } fwd_sel_t;

    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/vliw_fwd_select.sv
// Priority match of one source operand against every in-flight tracker entry.
// Optional feature macro: VLIW_HDU_ZERO_REG_EN (operands naming r0 never match).
module vliw_fwd_select
    import vliw_pkg::*;
#(
    parameter int LANES  = 2,
    parameter int STAGES = 3,
    parameter int REG_AW = 3
) (
    input  logic                            src_valid,
    input  logic [REG_AW-1:0]               src_reg,
    input  trk_entry_t [STAGES*LANES-1:0]   entries,
    output fwd_sel_t                        sel,
    output logic                            load_hazard
);

    logic                 op_en;
    logic                 found;
    logic                 win_load;
    logic [SEL_W_MAX-1:0] win_s;
    logic [SEL_W_MAX-1:0] win_m;

`ifdef VLIW_HDU_ZERO_REG_EN
    assign op_en = src_valid && (src_reg != '0);
`else
    assign op_en = src_valid;
`endif

    // Oldest stage scanned first so younger stages, and later lanes within a stage, overwrite.
    always_comb begin
        found    = 1'b0;
        win_load = 1'b0;
        win_s    = '0;
        win_m    = '0;
        for (int s = STAGES - 1; s >= 0; s--) begin
            for (int m = 0; m < LANES; m++) begin
                if (op_en && entries[s*LANES+m].valid &&
                    entries[s*LANES+m].dreg == REG_AW_MAX'(src_reg)) begin
                    found    = 1'b1;
                    win_load = entries[s*LANES+m].is_load;
                    win_s    = SEL_W_MAX'(s);
                    win_m    = SEL_W_MAX'(m);
                end
            end
        end
    end

    // A load still in EX has no data yet: report a hazard instead of a forward.
    always_comb begin
        load_hazard = found && (win_s == SEL_W_MAX'(STG_EX)) && win_load;
        sel.hit     = found && !load_hazard;
        sel.stage   = sel.hit ? win_s : '0;
        sel.lane    = sel.hit ? win_m : '0;
    end

endmodule

// File: rtl/vliw_hazard_fwd_unit.sv
// Multi-lane hazard detection and forwarding control: in-flight write tracker, load-use stall, stall counter.
// Optional feature macro: VLIW_HDU_ZERO_REG_EN (register 0 hard-wired to zero).
module vliw_hazard_fwd_unit
    import vliw_pkg::*;
#(
    parameter int LANES  = 2,
    parameter int SRCS   = 2,
    parameter int NREGS  = 8,
    parameter int STAGES = 3,
    parameter int CNT_W  = 16,
    localparam int REG_AW = $clog2(NREGS),
    localparam int STG_W  = idx_w(STAGES),
    localparam int LANE_W = idx_w(LANES)
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [LANES-1:0]              issue_valid,
    input  logic [LANES-1:0]              dst_we,
    input  logic [LANES-1:0]              dst_is_load,
    input  logic [LANES*REG_AW-1:0]       dst_reg,
    input  logic [LANES*SRCS-1:0]         src_valid,
    input  logic [LANES*SRCS*REG_AW-1:0]  src_reg,
    input  logic                          flush,
    output logic [LANES*SRCS-1:0]         fwd_hit,
    output logic [LANES*SRCS*STG_W-1:0]   fwd_stage,
    output logic [LANES*SRCS*LANE_W-1:0]  fwd_lane,
    output logic                          stall,
    output logic                          pc_write,
    output logic                          ifid_write,
    output logic [CNT_W-1:0]              stall_count
);

    localparam int NOPS = LANES * SRCS;

    trk_entry_t [STAGES*LANES-1:0] trk_q;
    trk_entry_t [LANES-1:0]        ent_d;
    fwd_sel_t                      sel [NOPS];
    logic [NOPS-1:0]               op_hazard;
    logic                          unused_sel;

    for (genvar i = 0; i < NOPS; i++) begin : g_op
        vliw_fwd_select #(
            .LANES  (LANES),
            .STAGES (STAGES),
            .REG_AW (REG_AW)
        ) u_sel (
            .src_valid   (src_valid[i]),
            .src_reg     (src_reg[i*REG_AW +: REG_AW]),
            .entries     (trk_q),
            .sel         (sel[i]),
            .load_hazard (op_hazard[i])
        );
        assign fwd_hit[i]                      = sel[i].hit;
        assign fwd_stage[i*STG_W +: STG_W]     = sel[i].stage[STG_W-1:0];
        assign fwd_lane[i*LANE_W +: LANE_W]    = sel[i].lane[LANE_W-1:0];
    end

    always_comb begin
        unused_sel = 1'b0;
        for (int i = 0; i < NOPS; i++) begin
            unused_sel = unused_sel ^ (^{sel[i].stage, sel[i].lane});
        end
    end

    // A flush squashes the held bundle, so it also cancels the stall.
    assign stall      = (|op_hazard) && !flush;
    assign pc_write   = !stall;
    assign ifid_write = !stall;

    always_comb begin
        ent_d = '0;
        for (int m = 0; m < LANES; m++) begin
            ent_d[m].valid   = issue_valid[m] && dst_we[m] && !stall && !flush;
`ifdef VLIW_HDU_ZERO_REG_EN
            if (dst_reg[m*REG_AW +: REG_AW] == '0) begin
                ent_d[m].valid = 1'b0;
            end
`endif
            ent_d[m].dreg    = REG_AW_MAX'(dst_reg[m*REG_AW +: REG_AW]);
            ent_d[m].is_load = dst_is_load[m];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            trk_q       <= '0;
            stall_count <= '0;
        end else begin
            for (int s = STAGES - 1; s > 0; s--) begin
                for (int m = 0; m < LANES; m++) begin
                    trk_q[s*LANES+m] <= trk_q[(s-1)*LANES+m];
                end
            end
            trk_q[LANES-1:0] <= ent_d;
            if (stall && (stall_count != {CNT_W{1'b1}})) begin
                stall_count <= stall_count + CNT_W'(1);
            end
        end
    end

endmodule
